// File: rtl/uart_ctrl_pkg.sv
// Shared types and helpers for the UART transmit-side arbiter.
// Holds the FSM state encoding, the default header tag and the header builder.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_e;

    localparam logic [4:0] HDR_TAG_DEFAULT = 5'b10101;

    // Header byte: tag in the upper five bits, requester ID in the lower three.
    function automatic logic [7:0] makeHeader(input logic [4:0] tag, input logic [2:0] id);
        return {tag, id};
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin search: the first valid requester after ptr_i,
// wrapping modulo N_REQ, as both a one-hot vector and an index.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    int               cand;
    logic [IDX_W-1:0] candIdx;

    // Walk from the farthest candidate to the nearest so the nearest valid one wins.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = 0;
        candIdx  = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand    = (int'(ptr_i) + k) % N_REQ;
            candIdx = IDX_W'(cand);
            if (valid_i[candIdx]) begin
                onehot_o          = '0;
                onehot_o[candIdx] = 1'b1;
                idx_o             = candIdx;
                any_o             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter in front of the UART TX FIFO write port.
// Each granted packet is prefixed with a header byte carrying the requester ID.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int         N_REQ   = 4,
    parameter logic [4:0] HDR_TAG = HDR_TAG_DEFAULT
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    input  logic [N_REQ-1:0]   req_last_i,
    output logic [N_REQ-1:0]   req_ready_o,
    output logic [N_REQ-1:0]   grant_o,
    output logic               busy_o,
    output logic [7:0]         w_data_o,
    output logic               wr_uart_o,
    input  logic               tx_full_i
);

    localparam int IDX_W = $clog2(N_REQ);

    state_e           state_q;
    logic [N_REQ-1:0] grant_q;
    logic [IDX_W-1:0] gid_q;
    logic [IDX_W-1:0] ptr_q;

    logic [N_REQ-1:0] pickOnehot;
    logic [IDX_W-1:0] pickIdx;
    logic             pickAny;
    logic             selValid;
    logic [7:0]       selData;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .valid_i  (req_valid_i),
        .ptr_i    (ptr_q),
        .onehot_o (pickOnehot),
        .idx_o    (pickIdx),
        .any_o    (pickAny)
    );

    assign selValid = req_valid_i[gid_q];
    assign selData  = req_data_i[8*gid_q +: 8];

    // The pointer moves only at packet end so the just-served requester drops to lowest priority.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            gid_q   <= '0;
            ptr_q   <= IDX_W'(N_REQ - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (pickAny) begin
                        grant_q <= pickOnehot;
                        gid_q   <= pickIdx;
                        state_q <= HDR;
                    end
                end
                HDR: begin
                    if (!tx_full_i) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (wr_uart_o && req_last_i[gid_q]) begin
                        ptr_q   <= gid_q;
                        grant_q <= '0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    always_comb begin
        w_data_o    = 8'h00;
        wr_uart_o   = 1'b0;
        req_ready_o = '0;
        case (state_q)
            HDR: begin
                w_data_o  = makeHeader(HDR_TAG, 3'(gid_q));
                wr_uart_o = !tx_full_i;
            end
            DATA: begin
                w_data_o           = selData;
                wr_uart_o          = selValid && !tx_full_i;
                req_ready_o[gid_q] = !tx_full_i;
            end
            default: begin
                w_data_o = 8'h00;
            end
        endcase
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single packet, rotation, backpressure,
// requester stall and asynchronous reset in the middle of a packet.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  reqValid;
    logic [31:0] reqData;
    logic [3:0]  reqLast;
    logic [3:0]  reqReady;
    logic [3:0]  grant;
    logic        busy;
    logic [7:0]  wData;
    logic        wrUart;
    logic        txFull;

    int total = 0;
    int bad   = 0;

    int   rrIds     [0:3];
    logic schedFull [0:6];

    uart_tx_arbiter #(
        .N_REQ   (4),
        .HDR_TAG (5'b10101)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .req_valid_i (reqValid),
        .req_data_i  (reqData),
        .req_last_i  (reqLast),
        .req_ready_o (reqReady),
        .grant_o     (grant),
        .busy_o      (busy),
        .w_data_o    (wData),
        .wr_uart_o   (wrUart),
        .tx_full_i   (txFull)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] last, input logic full);
        reqValid = valid;
        reqLast  = last;
        txFull   = full;
    endtask

    task automatic setData(input int id, input logic [7:0] b);
        reqData[8*id +: 8] = b;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        int   idx;
        int   writes;
        logic [3:0] oh;

        rrIds     = '{0, 1, 3, 0};
        schedFull = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        reset     = 1'b1;
        reqData   = '0;
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        tick();
        tick();

        checkOutput("rst_grant", grant, 4'b0000);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_wr", wrUart, 1'b0);
        checkOutput("rst_wdata", wData, 8'h00);
        checkOutput("rst_ready", reqReady, 4'b0000);
        reset = 1'b0;

        // single requester 2, two-byte packet
        setData(2, 8'hA1);
        applyStimulus(4'b0100, 4'b0000, 1'b0);
        #1;
        checkOutput("one_idle_wr", wrUart, 1'b0);
        checkOutput("one_idle_ready", reqReady, 4'b0000);
        checkOutput("one_idle_wdata", wData, 8'h00);
        tick();
        checkOutput("one_hdr_wr", wrUart, 1'b1);
        checkOutput("one_hdr_data", wData, 8'hAA);
        checkOutput("one_hdr_grant", grant, 4'b0100);
        checkOutput("one_hdr_busy", busy, 1'b1);
        checkOutput("one_hdr_ready", reqReady, 4'b0000);
        tick();
        checkOutput("one_d1_wr", wrUart, 1'b1);
        checkOutput("one_d1_data", wData, 8'hA1);
        checkOutput("one_d1_ready", reqReady, 4'b0100);
        tick();
        setData(2, 8'hB2);
        reqLast = 4'b0100;
        #1;
        checkOutput("one_d2_wr", wrUart, 1'b1);
        checkOutput("one_d2_data", wData, 8'hB2);
        checkOutput("one_d2_grant", grant, 4'b0100);
        tick();
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        #1;
        checkOutput("one_end_busy", busy, 1'b0);
        checkOutput("one_end_grant", grant, 4'b0000);
        checkOutput("one_end_wr", wrUart, 1'b0);

        // rotation among requesters 0, 1, 3 from reset
        reset = 1'b1;
        setData(0, 8'h10);
        setData(1, 8'h11);
        setData(3, 8'h13);
        applyStimulus(4'b1011, 4'b1011, 1'b0);
        tick();
        reset = 1'b0;
        for (int p = 0; p < 4; p++) begin
            oh = 4'b0001 << rrIds[p];
            #1;
            checkOutput($sformatf("rr%0d_idle_wr", p), wrUart, 1'b0);
            checkOutput($sformatf("rr%0d_idle_busy", p), busy, 1'b0);
            tick();
            checkOutput($sformatf("rr%0d_hdr_data", p), wData, 8'hA8 | 8'(rrIds[p]));
            checkOutput($sformatf("rr%0d_hdr_grant", p), grant, oh);
            tick();
            checkOutput($sformatf("rr%0d_dat_data", p), wData, 8'h10 | 8'(rrIds[p]));
            checkOutput($sformatf("rr%0d_dat_ready", p), reqReady, oh);
            tick();
            if (p == 3) begin
                applyStimulus(4'b0000, 4'b0000, 1'b0);
            end
        end

        // backpressure during a four-byte packet from requester 1
        setData(1, 8'hC0);
        applyStimulus(4'b0010, 4'b0000, 1'b0);
        #1;
        tick();
        checkOutput("bp_hdr_data", wData, 8'hA9);
        tick();
        idx    = 0;
        writes = 0;
        for (int c = 0; c < 7; c++) begin
            txFull = schedFull[c];
            setData(1, 8'(8'hC0 + idx));
            reqLast = (idx == 3) ? 4'b0010 : 4'b0000;
            #1;
            checkOutput($sformatf("bp%0d_wr", c), wrUart, !schedFull[c]);
            checkOutput($sformatf("bp%0d_ready", c), reqReady, schedFull[c] ? 4'b0000 : 4'b0010);
            if (!schedFull[c]) begin
                checkOutput($sformatf("bp%0d_data", c), wData, 8'(8'hC0 + idx));
                idx++;
            end
            if (wrUart) begin
                writes++;
            end
            tick();
        end
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        #1;
        checkOutput("bp_count", writes, 4);
        checkOutput("bp_end_busy", busy, 1'b0);

        // requester 2 stalls mid-packet while requester 1 waits
        setData(2, 8'hD0);
        setData(1, 8'hE1);
        applyStimulus(4'b0110, 4'b0010, 1'b0);
        #1;
        tick();
        checkOutput("st_hdr_data", wData, 8'hAA);
        checkOutput("st_hdr_grant", grant, 4'b0100);
        tick();
        checkOutput("st_d0_data", wData, 8'hD0);
        checkOutput("st_d0_wr", wrUart, 1'b1);
        tick();
        reqValid = 4'b0010;
        for (int s = 0; s < 5; s++) begin
            #1;
            checkOutput($sformatf("st%0d_wr", s), wrUart, 1'b0);
            checkOutput($sformatf("st%0d_grant", s), grant, 4'b0100);
            checkOutput($sformatf("st%0d_ready", s), reqReady, 4'b0100);
            tick();
        end
        reqValid = 4'b0110;
        reqLast  = 4'b0110;
        setData(2, 8'hD1);
        #1;
        checkOutput("st_d1_wr", wrUart, 1'b1);
        checkOutput("st_d1_data", wData, 8'hD1);
        tick();
        applyStimulus(4'b0010, 4'b0010, 1'b0);
        #1;
        checkOutput("st_gap_busy", busy, 1'b0);
        tick();
        checkOutput("st_r1_hdr", wData, 8'hA9);
        checkOutput("st_r1_grant", grant, 4'b0010);
        tick();
        checkOutput("st_r1_data", wData, 8'hE1);
        checkOutput("st_r1_ready", reqReady, 4'b0010);
        tick();
        applyStimulus(4'b0000, 4'b0000, 1'b0);

        // asynchronous reset in the middle of a packet from requester 3
        setData(3, 8'hF0);
        applyStimulus(4'b1000, 4'b0000, 1'b0);
        #1;
        tick();
        checkOutput("ar_hdr_data", wData, 8'hAB);
        tick();
        checkOutput("ar_d0_data", wData, 8'hF0);
        tick();
        setData(3, 8'hF1);
        #1;
        checkOutput("ar_d1_wr", wrUart, 1'b1);
        checkOutput("ar_d1_grant", grant, 4'b1000);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("ar_grant", grant, 4'b0000);
        checkOutput("ar_wr", wrUart, 1'b0);
        checkOutput("ar_ready", reqReady, 4'b0000);
        checkOutput("ar_busy", busy, 1'b0);
        checkOutput("ar_wdata", wData, 8'h00);
        setData(0, 8'h55);
        applyStimulus(4'b1001, 4'b1001, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        checkOutput("ar_idle_wr", wrUart, 1'b0);
        tick();
        txFull = 1'b1;
        #1;
        checkOutput("ar_hdr_full_wr", wrUart, 1'b0);
        checkOutput("ar_hdr_full_ready", reqReady, 4'b0000);
        checkOutput("ar_hdr_grant", grant, 4'b0001);
        tick();
        txFull = 1'b0;
        #1;
        checkOutput("ar_hdr_wr", wrUart, 1'b1);
        checkOutput("ar_hdr_data", wData, 8'hA8);
        tick();
        checkOutput("ar_r0_data", wData, 8'h55);
        checkOutput("ar_r0_ready", reqReady, 4'b0001);
        tick();
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        #1;
        checkOutput("ar_end_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
